// File: rtl/sd_pkg.sv
// Shared SD-card definitions: arbiter state encoding and last-served encoding.
package sd_pkg;

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_IDLE     = 3'd1,
    ST_RD_START = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_RD_BUSY  = 3'd4,
    ST_WR_START = 3'd5,
    ST_WR_WAIT  = 3'd6,
    ST_WR_BUSY  = 3'd7
  } arb_state_e;

  typedef enum logic {
    SRV_RD = 1'b0,
    SRV_WR = 1'b1
  } served_e;

  // Width of the operation timeout counter (covers BUSY_TIMEOUT up to 2^22).
  localparam int unsigned TIMER_W = 22;

endpackage

// File: rtl/sd_spi_arbiter_if.sv
// Bundle of init/read/write engine handshakes and the shared SD SPI lanes.
// master = arbiter side, slave = engines / card side.
interface sd_spi_arbiter_if;
  logic        init_done, init_clk, init_cs, init_mosi;
  logic        rd_req, wr_req;
  logic [31:0] rd_addr, wr_addr;
  logic        rd_start_en, wr_start_en;
  logic [31:0] rd_sec_addr, wr_sec_addr;
  logic        rd_busy, wr_busy;
  logic        rd_clk, rd_cs, rd_mosi, wr_clk, wr_cs, wr_mosi;
  logic        sd_clk, sd_cs, sd_mosi;
  logic        rd_done, wr_done, op_timeout, arb_idle;

  modport master (
    input  init_done, init_clk, init_cs, init_mosi,
    input  rd_req, rd_addr, wr_req, wr_addr, rd_busy, wr_busy,
    input  rd_clk, rd_cs, rd_mosi, wr_clk, wr_cs, wr_mosi,
    output rd_start_en, rd_sec_addr, wr_start_en, wr_sec_addr,
    output sd_clk, sd_cs, sd_mosi,
    output rd_done, wr_done, op_timeout, arb_idle
  );

  modport slave (
    output init_done, init_clk, init_cs, init_mosi,
    output rd_req, rd_addr, wr_req, wr_addr, rd_busy, wr_busy,
    output rd_clk, rd_cs, rd_mosi, wr_clk, wr_cs, wr_mosi,
    input  rd_start_en, rd_sec_addr, wr_start_en, wr_sec_addr,
    input  sd_clk, sd_cs, sd_mosi,
    input  rd_done, wr_done, op_timeout, arb_idle
  );
endinterface

// File: rtl/sd_op_timer.sv
// Operation watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the count reaches LIMIT-1.
module sd_op_timer
  import sd_pkg::*;
#(
  parameter int unsigned LIMIT = 2_000_000
) (
  input  logic clk_ref,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(LIMIT - 1);

  logic [TIMER_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (enable) cnt_d = cnt_q + TIMER_W'(1);
  end

  // Count register.
  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/sd_spi_arbiter.sv
// Arbitrates the SD card SPI lanes between the init, read and write engines,
// with round-robin tie breaking and a per-operation busy watchdog.
module sd_spi_arbiter
  import sd_pkg::*;
#(
  parameter int unsigned BUSY_TIMEOUT = 2_000_000
) (
  input  logic             clk_ref,
  input  logic             rst,
  sd_spi_arbiter_if.master bus
);

  arb_state_e  state_q, state_d;
  served_e     last_q, last_d;
  logic [31:0] rd_sec_q, rd_sec_d, wr_sec_q, wr_sec_d;
  logic        tmr_clear, tmr_enable, tmr_expired;
  logic        rd_start, wr_start, rd_done, wr_done, timeout, idle;

  sd_op_timer #(.LIMIT(BUSY_TIMEOUT)) u_timer (
    .clk_ref (clk_ref),
    .rst     (rst),
    .clear   (tmr_clear),
    .enable  (tmr_enable),
    .expired (tmr_expired)
  );

  assign tmr_clear  = (state_d == ST_RD_START) || (state_d == ST_WR_START);
  assign tmr_enable = (state_q == ST_RD_WAIT) || (state_q == ST_RD_BUSY) ||
                      (state_q == ST_WR_WAIT) || (state_q == ST_WR_BUSY);

  // Next-state, grant/latch decisions and pulse outputs.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    rd_sec_d = rd_sec_q;
    wr_sec_d = wr_sec_q;
    rd_start = 1'b0;
    wr_start = 1'b0;
    rd_done  = 1'b0;
    wr_done  = 1'b0;
    timeout  = 1'b0;
    idle     = 1'b0;
    unique case (state_q)
      ST_INIT: if (bus.init_done) state_d = ST_IDLE;
      ST_IDLE: begin
        idle = 1'b1;
        if (bus.rd_req && (!bus.wr_req || last_q == SRV_WR)) begin
          state_d  = ST_RD_START;
          last_d   = SRV_RD;
          rd_sec_d = bus.rd_addr;
        end else if (bus.wr_req) begin
          state_d  = ST_WR_START;
          last_d   = SRV_WR;
          wr_sec_d = bus.wr_addr;
        end
      end
      ST_RD_START: begin
        rd_start = 1'b1;
        state_d  = ST_RD_WAIT;
      end
      // Watchdog expiry takes priority over a same-cycle busy edge.
      ST_RD_WAIT: begin
        if (tmr_expired) begin timeout = 1'b1; state_d = ST_IDLE; end
        else if (bus.rd_busy) state_d = ST_RD_BUSY;
      end
      ST_RD_BUSY: begin
        if (tmr_expired) begin timeout = 1'b1; state_d = ST_IDLE; end
        else if (!bus.rd_busy) begin rd_done = 1'b1; state_d = ST_IDLE; end
      end
      ST_WR_START: begin
        wr_start = 1'b1;
        state_d  = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (tmr_expired) begin timeout = 1'b1; state_d = ST_IDLE; end
        else if (bus.wr_busy) state_d = ST_WR_BUSY;
      end
      ST_WR_BUSY: begin
        if (tmr_expired) begin timeout = 1'b1; state_d = ST_IDLE; end
        else if (!bus.wr_busy) begin wr_done = 1'b1; state_d = ST_IDLE; end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // State, last-served and latched sector addresses.
  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      state_q  <= ST_INIT;
      last_q   <= SRV_WR;
      rd_sec_q <= '0;
      wr_sec_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      rd_sec_q <= rd_sec_d;
      wr_sec_q <= wr_sec_d;
    end
  end

  // SPI lane mux, decoded from the registered state only.
  always_comb begin
    bus.sd_clk  = bus.init_clk;
    bus.sd_cs   = bus.init_cs;
    bus.sd_mosi = bus.init_mosi;
    unique case (state_q)
      ST_IDLE: begin
        bus.sd_clk  = 1'b0;
        bus.sd_cs   = 1'b1;
        bus.sd_mosi = 1'b1;
      end
      ST_RD_START, ST_RD_WAIT, ST_RD_BUSY: begin
        bus.sd_clk  = bus.rd_clk;
        bus.sd_cs   = bus.rd_cs;
        bus.sd_mosi = bus.rd_mosi;
      end
      ST_WR_START, ST_WR_WAIT, ST_WR_BUSY: begin
        bus.sd_clk  = bus.wr_clk;
        bus.sd_cs   = bus.wr_cs;
        bus.sd_mosi = bus.wr_mosi;
      end
      default: ;
    endcase
  end

  assign bus.rd_start_en = rd_start;
  assign bus.wr_start_en = wr_start;
  assign bus.rd_sec_addr = rd_sec_q;
  assign bus.wr_sec_addr = wr_sec_q;
  assign bus.rd_done     = rd_done;
  assign bus.wr_done     = wr_done;
  assign bus.op_timeout  = timeout;
  assign bus.arb_idle    = idle;

endmodule
